// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file.
package regfile_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set from issue, cleared by writeback or flush.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic [NREGS-1:0] clr,
  output logic [NREGS-1:0] busy,
  output logic             busy_any
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;

  // A new producer issued in the same cycle beats both retire-clear and flush.
  always_comb begin
    busy_nxt_s = {NREGS{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      busy_nxt_s[i] = (sb_set && !stall && (sb_addr == AW'(i)))
                    || (busy_r[i] && !clr[i] && !flush);
    end
  end

  // Busy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign busy_any = |busy_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass, stall hold and busy scoreboard.
module regfile_sb import regfile_pkg::*; #(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR-1:0][AW-1:0]    wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic                      sb_set,
  input  logic [AW-1:0]             sb_addr,
  output logic                      busy_any
);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NWR-1:0]   wr_eff_s;
  logic [NREGS-1:0] wr_clr_s;
  logic [NREGS-1:0] busy_s;

  // Effective writes: x0 is hardwired, stall freezes all commits.
  always_comb begin
    wr_eff_s = {NWR{1'b0}};
    for (int w = 0; w < NWR; w++) begin
      wr_eff_s[w] = wr_en[w] && !stall && (wr_addr[w] != {AW{1'b0}});
    end
  end

  // Retire-clear vector for the scoreboard.
  always_comb begin
    wr_clr_s = {NREGS{1'b0}};
    for (int w = 0; w < NWR; w++) begin
      for (int i = 0; i < NREGS; i++) begin
        wr_clr_s[i] = wr_clr_s[i] | (wr_eff_s[w] && (wr_addr[w] == AW'(i)));
      end
    end
  end

  // Storage; ascending port order lets the highest-index port win a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_eff_s[w]) begin
          regs_r[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  // Read muxes with bypass from the highest-index matching committing write.
  always_comb begin
    rd_data = {(NRD*XLEN){1'b0}};
    rd_busy = {NRD{1'b0}};
    for (int r = 0; r < NRD; r++) begin
      logic            hit_s;
      logic [XLEN-1:0] data_s;
      hit_s  = 1'b0;
      data_s = regs_r[rd_addr[r]];
      for (int w = 0; w < NWR; w++) begin
        data_s = (wr_eff_s[w] && (wr_addr[w] == rd_addr[r])) ? wr_data[w] : data_s;
        hit_s  = hit_s | (wr_eff_s[w] && (wr_addr[w] == rd_addr[r]));
      end
      rd_data[r] = data_s;
      rd_busy[r] = busy_s[rd_addr[r]] && !hit_s;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .clr      (wr_clr_s),
    .busy     (busy_s),
    .busy_any (busy_any)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = DEF_AW;
  localparam int XLEN  = DEF_XLEN;
  localparam int NREGS = DEF_NREGS;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     stall, flush, sb_set;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [AW-1:0]            sb_addr;
  logic                     busy_any;

  int total = 0;
  int bad   = 0;

  xlen_t mreg  [NREGS];
  logic  mbusy [NREGS];

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic m_eff(int w);
    return wr_en[w] && !stall && (wr_addr[w] != 0);
  endfunction

  function automatic xlen_t exp_data(int r);
    xlen_t d;
    d = (rd_addr[r] == 0) ? '0 : mreg[rd_addr[r]];
    for (int w = 0; w < NWR; w++)
      if (m_eff(w) && wr_addr[w] == rd_addr[r]) d = wr_data[w];
    return d;
  endfunction

  function automatic logic exp_busy(int r);
    if (rd_addr[r] == 0) return 1'b0;
    for (int w = 0; w < NWR; w++)
      if (m_eff(w) && wr_addr[w] == rd_addr[r]) return 1'b0;
    return mbusy[rd_addr[r]];
  endfunction

  function automatic logic exp_any();
    logic a = 1'b0;
    for (int i = 0; i < NREGS; i++) a |= mbusy[i];
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic model_commit();
    if (flush) begin
      for (int i = 0; i < NREGS; i++) mbusy[i] = 1'b0;
    end
    for (int w = 0; w < NWR; w++) begin
      if (m_eff(w)) begin
        mreg[wr_addr[w]]  = wr_data[w];
        mbusy[wr_addr[w]] = 1'b0;
      end
    end
    if (sb_set && !stall && sb_addr != 0) mbusy[sb_addr] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < NRD; r++) begin
      check($sformatf("%s_data%0d", tag, r), rd_data[r], exp_data(r));
      check($sformatf("%s_busy%0d", tag, r), {31'd0, rd_busy[r]}, {31'd0, exp_busy(r)});
    end
    check($sformatf("%s_any", tag), {31'd0, busy_any}, {31'd0, exp_any()});
  endtask

  task automatic tick();
    if (!rst) model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; sb_set = 1'b0; sb_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset contents on both ports
    for (int i = 0; i < NREGS; i++) begin
      rd_addr[0] = AW'(i);
      rd_addr[1] = AW'(NREGS - 1 - i);
      #1;
      check("reset_rd0", rd_data[0], 32'h0);
      check("reset_rd1", rd_data[1], 32'h0);
      check("reset_busy", {30'd0, rd_busy}, 32'h0);
      check("reset_any", {31'd0, busy_any}, 32'h0);
    end

    // x0 is hardwired zero
    wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hDEADBEEF; rd_addr = '0;
    #1 check("x0_bypass", rd_data[0], 32'h0);
    tick();
    wr_en = '0;
    #1 check("x0_stored", rd_data[0], 32'h0);

    // same-address collision: higher port wins
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; rd_addr[0] = 5'd5;
    #1 check("x5_bypass", rd_data[0], 32'h22);
    check_all("x5_bypass_m");
    tick();
    wr_en = '0;
    #1 check("x5_stored", rd_data[0], 32'h22);

    // stall holds the write and suppresses bypass
    stall = 1'b1; wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'hAA; rd_addr[0] = 5'd7;
    #1 check("x7_stall_rd", rd_data[0], 32'h0);
    repeat (3) begin
      tick();
      check("x7_stall_hold", rd_data[0], 32'h0);
    end
    stall = 1'b0;
    #1 check("x7_release_bypass", rd_data[0], 32'hAA);
    tick();
    wr_en = '0;
    #1 check("x7_stored", rd_data[0], 32'hAA);

    // scoreboard set then writeback clears
    sb_set = 1'b1; sb_addr = 5'd9; rd_addr[0] = 5'd9;
    tick();
    sb_set = 1'b0;
    #1 check("x9_busy", {31'd0, rd_busy[0]}, 32'h1);
    check("x9_any", {31'd0, busy_any}, 32'h1);
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h55;
    #1 check("x9_wb_busy", {31'd0, rd_busy[0]}, 32'h0);
    check("x9_wb_data", rd_data[0], 32'h55);
    tick();
    wr_en = '0;
    #1 check("x9_cleared_any", {31'd0, busy_any}, 32'h0);

    // set beats clear; flush keeps only the new producer
    sb_set = 1'b1; sb_addr = 5'd3; wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h33;
    tick();
    wr_en = '0; sb_addr = 5'd6;
    tick();
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd6; sb_set = 1'b0;
    #1 check("x3_busy", {31'd0, rd_busy[0]}, 32'h1);
    check("x6_busy", {31'd0, rd_busy[1]}, 32'h1);
    flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd4;
    tick();
    flush = 1'b0; sb_set = 1'b0; rd_addr[1] = 5'd4;
    #1 check("flush_x3", {31'd0, rd_busy[0]}, 32'h0);
    check("flush_x4", {31'd0, rd_busy[1]}, 32'h1);
    rd_addr[0] = 5'd6;
    #1 check("flush_x6", {31'd0, rd_busy[0]}, 32'h0);
    check("flush_any", {31'd0, busy_any}, 32'h1);

    // async reset mid-stall with pending writes
    sb_set = 1'b1; sb_addr = 5'd12;
    tick();
    sb_set = 1'b0; stall = 1'b1; wr_en = 2'b11;
    wr_addr[0] = 5'd12; wr_addr[1] = 5'd13; wr_data[0] = 32'h1212; wr_data[1] = 32'h1313;
    rd_addr[0] = 5'd12; rd_addr[1] = 5'd5;
    #2 rst = 1'b1;
    model_reset();
    #1 check("rst_rd0", rd_data[0], 32'h0);
    check("rst_rd1", rd_data[1], 32'h0);
    check("rst_any", {31'd0, busy_any}, 32'h0);
    check("rst_busy", {30'd0, rd_busy}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    wr_en = '0; stall = 1'b0; rd_addr[1] = 5'd13;
    tick();
    check("rst_no_write12", rd_data[0], 32'h0);
    check("rst_no_write13", rd_data[1], 32'h0);
    check_all("post_rst");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      sb_set = ($urandom_range(0, 2) == 0);
      sb_addr = AW'($urandom_range(0, NREGS - 1));
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]   = $urandom_range(0, 1);
        wr_addr[w] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
        wr_data[w] = $urandom;
      end
      for (int r = 0; r < NRD; r++) begin
        rd_addr[r] = $urandom_range(0, 1) ? wr_addr[$urandom_range(0, NWR - 1)]
                                          : AW'($urandom_range(0, NREGS - 1));
      end
      #1 check_all("rnd");
      tick();
    end

    idle();
    #1 check_all("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
